// File: rtl/fnd_source_scheduler.sv
// FND source scheduler: picks which source drives the 4-digit display, with timed overlays and blink.
// Optional leading-zero blanking is enabled by defining FND_LZ_BLANK_EN.
module fnd_source_scheduler #(
  parameter int CLK_PER_MS = 100000,
  parameter int HOLD_MS    = 3000,
  parameter int BLINK_MS   = 500,
  parameter int MAX_VAL    = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [1:0]  air_state,
  input  logic [55:0] src_data,
  input  logic [3:0]  ovl_req,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  ovl_ack,
  output logic [13:0] disp_data,
  output logic [1:0]  disp_src,
  output logic [3:0]  disp_blank,
  output logic        overlay_active
);

  localparam int MSW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int HW  = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam int BW  = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [MSW-1:0] MS_LAST    = MSW'(CLK_PER_MS - 1);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_MS - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_MS - 1);
  localparam logic [13:0]    MAX14      = 14'(MAX_VAL);

  typedef enum logic {BASE, OVERLAY} state_t;

  state_t         state, state_n;
  logic [1:0]     winner, winner_n;
  logic [3:0]     pending, pending_n;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic [MSW-1:0] ms_cnt;
  logic           ms_tick;
  logic [BW-1:0]  blink_cnt, blink_cnt_n;
  logic           phase, phase_n;
  logic           mask_nz_q, blink_start;
  logic [3:0]     ack_n, cand;
  logic [1:0]     req_lo, base_src, shown_n;
  logic [13:0]    src [4];
  logic [13:0]    sel_val, sat_val;
  logic [3:0]     blank_n;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign src[g] = src_data[g*14 +: 14];
  end

  assign ms_tick     = (ms_cnt == MS_LAST);
  assign blink_start = (|blink_mask) & ~mask_nz_q;

  always_comb begin
    base_src = 2'd2;
    case (mode)
      2'b00:   base_src = 2'd0;
      2'b01:   base_src = 2'd1;
      2'b10:   base_src = (air_state == 2'b11) ? 2'd3 : 2'd2;
      default: base_src = 2'd2;
    endcase
  end

  // Overlay arbitration: lower index preempts, higher index queues, expiry chains straight into the next pending source.
  always_comb begin
    state_n   = state;
    winner_n  = winner;
    pending_n = pending;
    hold_n    = hold_cnt;
    ack_n     = '0;
    req_lo    = lowest(ovl_req);
    cand      = ovl_req | pending;
    case (state)
      BASE: begin
        if (|cand) begin
          state_n   = OVERLAY;
          winner_n  = lowest(cand);
          pending_n = cand & ~onehot(winner_n);
          ack_n     = onehot(winner_n);
          hold_n    = '0;
        end
      end
      default: begin
        if ((|ovl_req) && (req_lo <= winner)) begin
          winner_n  = req_lo;
          pending_n = (pending | ovl_req) & ~onehot(req_lo);
          ack_n     = onehot(req_lo);
          hold_n    = '0;
        end else begin
          pending_n = pending | ovl_req;
          if (ms_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_n = '0;
              if (|pending_n) begin
                winner_n  = lowest(pending_n);
                pending_n = pending_n & ~onehot(winner_n);
                ack_n     = onehot(winner_n);
              end else begin
                state_n = BASE;
              end
            end else begin
              hold_n = hold_cnt + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    blink_cnt_n = blink_cnt;
    phase_n     = phase;
    if (blink_start) begin
      blink_cnt_n = '0;
      phase_n     = 1'b0;
    end else if (ms_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_n = '0;
        phase_n     = ~phase;
      end else begin
        blink_cnt_n = blink_cnt + 1'b1;
      end
    end
  end

  // Outputs are computed from next-state so they change on the same edge as the state itself.
  always_comb begin
    shown_n = (state_n == OVERLAY) ? winner_n : base_src;
    sel_val = src[shown_n];
    sat_val = (sel_val > MAX14) ? MAX14 : sel_val;
    blank_n = blink_mask & {4{phase_n}};
`ifdef FND_LZ_BLANK_EN
    blank_n = blank_n | {sat_val < 14'd1000, sat_val < 14'd100, sat_val < 14'd10, 1'b0};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BASE;
      winner         <= '0;
      pending        <= '0;
      hold_cnt       <= '0;
      ms_cnt         <= '0;
      blink_cnt      <= '0;
      phase          <= 1'b0;
      mask_nz_q      <= 1'b0;
      ovl_ack        <= '0;
      disp_data      <= '0;
      disp_src       <= '0;
      disp_blank     <= '0;
      overlay_active <= 1'b0;
    end else begin
      state          <= state_n;
      winner         <= winner_n;
      pending        <= pending_n;
      hold_cnt       <= hold_n;
      ms_cnt         <= ms_tick ? '0 : ms_cnt + 1'b1;
      blink_cnt      <= blink_cnt_n;
      phase          <= phase_n;
      mask_nz_q      <= |blink_mask;
      ovl_ack        <= ack_n;
      disp_data      <= sat_val;
      disp_src       <= shown_n;
      disp_blank     <= blank_n;
      overlay_active <= (state_n == OVERLAY);
    end
  end

endmodule

// File: doc/fnd_source_scheduler.md
Name: fnd_source_scheduler

Overview:
- Arbitrates the shared 4-digit FND datapath between the stopwatch, microwave, temp/humidity and set-temperature sources.
- Selects a base source from the top-level mode and air sub-state.
- Grants timed overlay windows to sources that request temporary display, for example a set-point change shown while in another mode.
- Drives the value, source id and per-digit blank mask into the FND digit-scan/BCD datapath, with a 1-cycle registered output.

Parameters:
- CLK_PER_MS, 100000, clk cycles per 1 ms tick
- HOLD_MS, 3000, overlay window length in ms
- BLINK_MS, 500, blink half-period in ms
- MAX_VAL, 9999, saturation limit for displayed value

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- mode  input  2  top mode: 00 stopwatch, 01 microwave, 10 air handler, 11 reserved
- air_state  input  2  air sub-FSM: 00 manual, 01 auto, 10 stopped, 11 set-temp
- src_data  input  56  four 14-bit source values; [13:0]=src0 stopwatch, [27:14]=src1 oven, [41:28]=src2 tem/hum, [55:42]=src3 set-temp
- ovl_req  input  4  per-source overlay request pulses, 1 cycle each
- blink_mask  input  4  digits to blink; bit0=d1 … bit3=d1000
- ovl_ack  output  4  1-cycle pulse when a source's overlay window starts or restarts
- disp_data  output  14  value to display, saturated to MAX_VAL
- disp_src  output  2  index of the source currently shown
- disp_blank  output  4  per-digit blank; 1 = digit off
- overlay_active  output  1  high while in OVERLAY state

Behaviour:
- Reset values: all outputs 0; FSM=BASE; pending=0; timers and blink phase=0 (phase 0 = visible).
- ms tick: free-running counter 0..CLK_PER_MS-1. ms_tick is asserted for 1 cycle on wrap.
- Base selection (combinational):
  - mode 00 -> src0
  - mode 01 -> src1
  - mode 10 -> src3 if air_state==11, else src2
  - mode 11 -> src2
- FSM BASE:
  - Shown source = base source.
  - Any ovl_req bit, or any pending bit, -> OVERLAY with winner = lowest set index among (ovl_req | pending).
  - On entry: pulse ovl_ack[winner], clear pending[winner], load hold timer = 0.
- FSM OVERLAY:
  - Shown source = winner, with live src_data (not a snapshot).
  - Hold timer increments on ms_tick. At HOLD_MS-1 plus a tick -> BASE, or directly re-enter OVERLAY for the next pending index (same cycle, no BASE gap cycle).
  - ovl_req[winner] again: timer restarts to 0, ovl_ack[winner] pulses.
  - ovl_req from a lower index (higher priority): preempt. The current winner is NOT re-queued; new winner set, timer=0, ack pulses.
  - ovl_req from a higher index: set pending bit, no ack until served.
  - Simultaneous requests: lowest index wins; the remainder go to pending.
- Overlay timer is independent of mode/air_state changes; a mode change mid-overlay only alters the post-overlay base.
- Registered outputs, updated every cycle:
  - disp_data = min(selected value, MAX_VAL)
  - disp_src = shown index
  - overlay_active = (state==OVERLAY)
- Blink:
  - Phase toggles every BLINK_MS ms ticks.
  - The phase counter and phase reset to visible when blink_mask transitions from 0 to non-zero.
  - disp_blank = blink_mask & {4{phase}}.
- Reset asserted mid-overlay: immediate return to BASE; pending cleared; no ack.

Optional Feature:
- Macro FND_LZ_BLANK_EN.
- When defined: leading zeros are blanked. d1000 is blanked if disp_data<1000, d100 if <100, d10 if <10; d1 is never blanked. These bits are ORed into disp_blank.
- When undefined: only blink drives disp_blank; zeros are displayed.

Test Plan (CLK_PER_MS=4, HOLD_MS=5, BLINK_MS=2):
- Reset, then mode=10, air_state=11, src3=25 -> after 1 cycle: disp_src=3, disp_data=25, disp_blank=0, all acks 0.
- mode=00, src0=1234; pulse ovl_req[2] with src2=5560 -> ovl_ack[2] pulses 1 cycle. disp_src=2 and disp_data=5560 hold for 20 clk, then disp_src=0 and disp_data=1234.
- In overlay on src2, pulse ovl_req[3] then ovl_req[1] -> ack[1] immediately (preempt); src1 shown 20 clk; then ack[3] and src3 shown 20 clk with no BASE cycle between; src2 not revisited.
- src0=16000 in mode 00 -> disp_data=9999.
- blink_mask=0011 -> disp_blank alternates 0000 / 0011 every 8 clk, starting visible. With FND_LZ_BLANK_EN and disp_data=42 -> visible-phase disp_blank=1100.
- Reset asserted during overlay with pending[3] set -> overlay_active=0 and base source shown after reset release; no ack[3] afterwards.
